// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM shared-line receiver.
package tdm_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  localparam int N_CH_DEF   = 4;
  localparam int WORD_W_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/tdm_bus_demux_rx_if.sv
// Parallel word-set output handshake of the TDM receiver.
interface tdm_bus_demux_rx_if #(
  parameter int N_CH   = 4,
  parameter int WORD_W = 8
);
  logic [N_CH*WORD_W-1:0] data_out;
  logic                   out_valid;
  logic                   out_ready;

  modport master (output data_out, output out_valid, input out_ready);
  modport slave  (input data_out, input out_valid, output out_ready);
endinterface

// File: rtl/tdm_slot_counter.sv
// Slot select and bit position counters; slot wraps every N_CH cycles, bit on slot wrap.
import tdm_pkg::*;

module tdm_slot_counter #(
  parameter int N_CH   = N_CH_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int SEL_W  = clog2(N_CH),
  parameter int BIT_W  = (clog2(WORD_W) > 0) ? clog2(WORD_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  output logic [SEL_W-1:0] sel,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             wrap,
  output logic             last_bit
);

  assign wrap     = en && (sel == SEL_W'(N_CH - 1));
  assign last_bit = wrap && (bit_cnt == BIT_W'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sel     <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      sel <= wrap ? '0 : sel + 1'b1;
      if (wrap)
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_bus_demux_rx.sv
// Receiver for the tri-state shared bus: walks the slot select, samples the wire,
// rebuilds N_CH serial words (MSB first) and hands them off with valid/ready.
import tdm_pkg::*;

module tdm_bus_demux_rx #(
  parameter int N_CH   = N_CH_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int SEL_W  = clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                bus_in,
  output logic [SEL_W-1:0]    sel_out,
  output logic                frame_start,
  output logic                overrun,
  input  logic                ovr_clr,
  tdm_bus_demux_rx_if.master  rx
);

  localparam int BIT_W = (clog2(WORD_W) > 0) ? clog2(WORD_W) : 1;

  state_e state, state_nx;

  logic [SEL_W-1:0]              sel;
  logic [BIT_W-1:0]              bit_cnt;
  logic                          wrap, last_bit, sample, load, drop;
  logic [N_CH-1:0][WORD_W-1:0]   shreg, shreg_nx;
  logic [N_CH*WORD_W-1:0]        data_q;
  logic                          valid_q, ovr_q;
  logic                          unused;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en)  state_nx = RUN;
      RUN:     if (!en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Dropping en in RUN is an abort: no sample that cycle and counters restart.
  assign sample = (state == RUN) && en;

  tdm_slot_counter #(
    .N_CH(N_CH), .WORD_W(WORD_W), .SEL_W(SEL_W), .BIT_W(BIT_W)
  ) u_cnt (
    .clk(clk), .rst_n(rst_n), .en(sample), .clear(!sample),
    .sel(sel), .bit_cnt(bit_cnt), .wrap(wrap), .last_bit(last_bit)
  );

  assign unused = ^{bit_cnt, wrap};

  always_comb begin
    shreg_nx = shreg;
    for (int i = 0; i < N_CH; i++)
      if (sel == SEL_W'(i))
        shreg_nx[i] = {shreg[i][WORD_W-2:0], bus_in};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !sample) shreg <= '0;
    else                   shreg <= shreg_nx;
  end

  // Completion captures shreg_nx so the final bit sampled this edge is included.
  assign load = last_bit && (!valid_q || rx.out_ready);
  assign drop = last_bit && !load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (load) data_q <= shreg_nx;

      if (load)              valid_q <= 1'b1;
      else if (rx.out_ready) valid_q <= 1'b0;

      if (drop)         ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;
    end
  end

  assign sel_out      = sel;
  assign frame_start  = (state == RUN) && (sel == '0);
  assign overrun      = ovr_q;
  assign rx.data_out  = data_q;
  assign rx.out_valid = valid_q;

endmodule

// File: tb/tb_tdm_bus_demux_rx.sv
// Directed bench for tdm_bus_demux_rx: word sets driven slot by slot on the shared line.
module tb_tdm_bus_demux_rx;

  logic       clk = 1'b0;
  logic       rst_n, en, bus_in, ovr_clr;
  logic [1:0] sel_out;
  logic       frame_start, overrun;
  int         checks = 0;
  int         errors = 0;

  tdm_bus_demux_rx_if #(.N_CH(4), .WORD_W(8)) rx ();

  tdm_bus_demux_rx #(.N_CH(4), .WORD_W(8), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus_in(bus_in),
    .sel_out(sel_out), .frame_start(frame_start),
    .overrun(overrun), .ovr_clr(ovr_clr), .rx(rx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full 32-cycle word set starting at slot 0 and counts slot/frame
  // sequence deviations; positioned at slot 0 of the next set on return.
  task automatic run_set(input logic [7:0] w0, w1, w2, w3,
                         input logic rdy, input logic rdy_last,
                         input int clr_at, output int bad);
    logic [7:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    bad = 0;
    for (int c = 0; c < 32; c++) begin
      if (sel_out !== 2'(c % 4) || frame_start !== (c % 4 == 0)) bad++;
      bus_in       = w[c % 4][7 - c / 4];
      rx.out_ready = (c == 31) ? rdy_last : rdy;
      ovr_clr      = (c == clr_at);
      tick();
    end
    ovr_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; bus_in = 1'b1; ovr_clr = 1'b0; rx.out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++;
    if ({rx.data_out, rx.out_valid, overrun, sel_out, frame_start} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h valid=%b ovr=%b sel=%0d fs=%b, want all 0",
               rx.data_out, rx.out_valid, overrun, sel_out, frame_start);
    end
    tick();
    checks++;
    if (sel_out !== 2'd0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got sel=%0d fs=%b, want 0 0", sel_out, frame_start);
    end
  endtask

  task automatic test_first_set();
    int bad;
    rx.out_ready = 1'b1; en = 1'b1;
    tick();
    checks++;
    if (rx.out_valid !== 1'b0) begin
      errors++; $display("FAIL first_pre_valid: got %b want 0", rx.out_valid);
    end
    run_set(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b1, -1, bad);
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL first_slot_seq: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (rx.out_valid !== 1'b1 || rx.data_out !== 32'h00FF3CA5) begin
      errors++;
      $display("FAIL first_set: got valid=%b data=%h want 1 00ff3ca5", rx.out_valid, rx.data_out);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    run_set(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b1, -1, bad);
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL b2b_slot_seq: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (rx.out_valid !== 1'b1 || rx.data_out !== 32'h04030201 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_set: got valid=%b data=%h ovr=%b want 1 04030201 0",
               rx.out_valid, rx.data_out, overrun);
    end
  endtask

  task automatic test_overrun();
    int bad;
    // held set not consumed; completion drops, clear on the drop cycle loses
    run_set(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 31, bad);
    checks++;
    if (rx.out_valid !== 1'b1 || rx.data_out !== 32'h04030201 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drop: got valid=%b data=%h ovr=%b want 1 04030201 1",
               rx.out_valid, rx.data_out, overrun);
    end
    run_set(8'h55, 8'h66, 8'h77, 8'h88, 1'b1, 1'b1, 3, bad);
    checks++;
    if (rx.out_valid !== 1'b1 || rx.data_out !== 32'h88776655 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got valid=%b data=%h ovr=%b want 1 88776655 0",
               rx.out_valid, rx.data_out, overrun);
    end
  endtask

  task automatic test_abort();
    int bad;
    for (int c = 0; c < 21; c++) begin
      bus_in = 1'b1;
      tick();
    end
    checks++;
    if (sel_out !== 2'd1) begin
      errors++; $display("FAIL abort_pos: got sel=%0d want 1", sel_out);
    end
    en = 1'b0;
    tick();
    checks++;
    if (sel_out !== 2'd0 || frame_start !== 1'b0 || rx.out_valid !== 1'b0 ||
        rx.data_out !== 32'h88776655) begin
      errors++;
      $display("FAIL abort_idle: got sel=%0d fs=%b valid=%b data=%h want 0 0 0 88776655",
               sel_out, frame_start, rx.out_valid, rx.data_out);
    end
    tick();
    en = 1'b1;
    tick();
    run_set(8'hC3, 8'h5A, 8'h81, 8'h7E, 1'b1, 1'b1, -1, bad);
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL abort_slot_seq: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (rx.out_valid !== 1'b1 || rx.data_out !== 32'h7E815AC3) begin
      errors++;
      $display("FAIL abort_reentry: got valid=%b data=%h want 1 7e815ac3", rx.out_valid, rx.data_out);
    end
  endtask

  task automatic test_same_cycle();
    int bad;
    run_set(8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 1'b1, -1, bad);
    checks++;
    if (rx.out_valid !== 1'b1 || rx.data_out !== 32'h40302010 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle: got valid=%b data=%h ovr=%b want 1 40302010 0",
               rx.out_valid, rx.data_out, overrun);
    end
  endtask

  task automatic test_reset_mid_run();
    rx.out_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      bus_in = c[0];
      tick();
    end
    checks++;
    if (sel_out !== 2'd2 || frame_start !== 1'b0) begin
      errors++; $display("FAIL mid_pos: got sel=%0d fs=%b want 2 0", sel_out, frame_start);
    end
    rst_n = 1'b0; en = 1'b0;
    tick();
    checks++;
    if ({rx.data_out, rx.out_valid, overrun, sel_out, frame_start} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got data=%h valid=%b ovr=%b sel=%0d fs=%b want all 0",
               rx.data_out, rx.out_valid, overrun, sel_out, frame_start);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (sel_out !== 2'd0 || frame_start !== 1'b0 || rx.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got sel=%0d fs=%b valid=%b want 0 0 0",
               sel_out, frame_start, rx.out_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_set();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_same_cycle();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
